// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: occupancy-state
// encoding and default field widths.
package pipe_pkg;

  // The encoding equals the number of held entries, so the state value
  // doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_t;

  localparam int NB_CTRL_DEF = 10;
  localparam int NB_DATA_DEF = 138;

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake on both sides.
// SKID=1: main + skid entry, o_ready comes straight from a flop.
// SKID=0: single main entry, o_ready = !o_valid || i_ready.
//
// Handshake: an entry moves across an interface on a rising edge where
// valid && ready are both high; the sender holds its entry stable until
// then, and the receiver may raise or drop ready freely.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int NB_CTRL = NB_CTRL_DEF,
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int SKID    = 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_flush,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [NB_CTRL-1:0] i_ctrl,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_CTRL-1:0] o_ctrl,
  output logic [NB_DATA-1:0] o_data,
  output logic [1:0]         o_count,
  output logic [1:0]         o_state
);

  pipe_state_t        state_q, state_d;
  logic               ready_q, ready_d;
  logic [NB_CTRL-1:0] main_ctrl_q, skid_ctrl_q;
  logic [NB_DATA-1:0] main_data_q, skid_data_q;
  logic               accept, retire;
  logic               load_main_in, load_skid_in, move_skid;

  assign o_valid = (state_q != ST_EMPTY);
  assign o_ready = (SKID != 0) ? ready_q : (!o_valid || i_ready);
  assign accept  = i_valid && o_ready;
  assign retire  = o_valid && i_ready;

  // Control is squashed to zero on bubbles; payload keeps its last value.
  assign o_ctrl  = o_valid ? main_ctrl_q : '0;
  assign o_data  = main_data_q;
  assign o_count = state_q;
  assign o_state = state_q;

  // Next-state and storage-load decisions; flush overrides accept/retire.
  always_comb begin
    state_d      = state_q;
    load_main_in = 1'b0;
    load_skid_in = 1'b0;
    move_skid    = 1'b0;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d      = ST_FULL;
            load_main_in = 1'b1;
          end
        end
        ST_FULL: begin
          if (accept && retire) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            // Only reachable with SKID=1: combinational ready blocks it otherwise.
            if (SKID != 0) begin
              state_d      = ST_SKID;
              load_skid_in = 1'b1;
            end
          end else if (retire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          // o_ready is low here, so the only event is a retire.
          if (retire) begin
            state_d   = ST_FULL;
            move_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    ready_d = (state_d != ST_SKID);
  end

  // State, registered ready and entry storage; reset beats flush.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_EMPTY;
      ready_q     <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      if (load_main_in) begin
        main_ctrl_q <= i_ctrl;
        main_data_q <= i_data;
      end else if (move_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_data_q <= skid_data_q;
      end
      if (load_skid_in) begin
        skid_ctrl_q <= i_ctrl;
        skid_data_q <= i_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance share the same
// stimulus; each has its own reference queue of expected entries.
module tb_pipe_stage_reg;

  localparam int CW = 10;
  localparam int DW = 138;
  localparam int EW = CW + DW;

  // Clock/reset block
  logic i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  logic          i_reset = 1'b0;
  logic          i_flush = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic [CW-1:0] i_ctrl  = '0;
  logic [DW-1:0] i_data  = '0;

  logic          o_ready_s, o_valid_s, o_ready_c, o_valid_c;
  logic [CW-1:0] o_ctrl_s, o_ctrl_c;
  logic [DW-1:0] o_data_s, o_data_c;
  logic [1:0]    o_count_s, o_count_c, o_state_s, o_state_c;

  pipe_stage_reg #(.NB_CTRL(CW), .NB_DATA(DW), .SKID(1)) dut_s (
    .i_clock(i_clock), .i_reset(i_reset), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready_s), .i_ctrl(i_ctrl), .i_data(i_data),
    .o_valid(o_valid_s), .i_ready(i_ready), .o_ctrl(o_ctrl_s), .o_data(o_data_s),
    .o_count(o_count_s), .o_state(o_state_s)
  );

  pipe_stage_reg #(.NB_CTRL(CW), .NB_DATA(DW), .SKID(0)) dut_c (
    .i_clock(i_clock), .i_reset(i_reset), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready_c), .i_ctrl(i_ctrl), .i_data(i_data),
    .o_valid(o_valid_c), .i_ready(i_ready), .o_ctrl(o_ctrl_c), .o_data(o_data_c),
    .o_count(o_count_c), .o_state(o_state_c)
  );

  // Scoreboard
  logic [EW-1:0] exp_q_s[$];
  logic [EW-1:0] exp_q_c[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  bit            armed    = 1'b0;

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW; i += 32) r = (r << 32) | DW'($urandom);
    return r;
  endfunction

  // Driver: one clock cycle. Inputs change on the falling edge, outputs are
  // compared against the reference queues just before the rising edge, and
  // the queues are updated with what that edge accepts/retires.
  task automatic cycle(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic rdy, input logic fl, input logic rs);
    logic ea_s, er_s, ea_c, er_c, rdy_s, rdy_c;
    @(negedge i_clock);
    i_valid = v; i_ctrl = c; i_data = d; i_ready = rdy; i_flush = fl; i_reset = rs;
    #1;
    rdy_s = (exp_q_s.size() < 2);
    rdy_c = (exp_q_c.size() == 0) || rdy;
    if (armed) begin
      n_checks++;
      if (o_valid_s !== (exp_q_s.size() != 0)) begin
        n_fail++; $display("FAIL skid_valid got %0b want %0b", o_valid_s, exp_q_s.size() != 0);
      end
      n_checks++;
      if (o_count_s !== 2'(exp_q_s.size())) begin
        n_fail++; $display("FAIL skid_count got %0d want %0d", o_count_s, exp_q_s.size());
      end
      n_checks++;
      if (o_ready_s !== rdy_s) begin
        n_fail++; $display("FAIL skid_ready got %0b want %0b", o_ready_s, rdy_s);
      end
      n_checks++;
      if (exp_q_s.size() != 0) begin
        if ({o_ctrl_s, o_data_s} !== exp_q_s[0]) begin
          n_fail++; $display("FAIL skid_entry got %h want %h", {o_ctrl_s, o_data_s}, exp_q_s[0]);
        end
      end else if (o_ctrl_s !== '0) begin
        n_fail++; $display("FAIL skid_bubble_ctrl got %h want 0", o_ctrl_s);
      end
      n_checks++;
      if (o_valid_c !== (exp_q_c.size() != 0)) begin
        n_fail++; $display("FAIL comb_valid got %0b want %0b", o_valid_c, exp_q_c.size() != 0);
      end
      n_checks++;
      if (o_count_c !== 2'(exp_q_c.size())) begin
        n_fail++; $display("FAIL comb_count got %0d want %0d", o_count_c, exp_q_c.size());
      end
      n_checks++;
      if (o_ready_c !== rdy_c) begin
        n_fail++; $display("FAIL comb_ready got %0b want %0b", o_ready_c, rdy_c);
      end
      n_checks++;
      if (exp_q_c.size() != 0) begin
        if ({o_ctrl_c, o_data_c} !== exp_q_c[0]) begin
          n_fail++; $display("FAIL comb_entry got %h want %h", {o_ctrl_c, o_data_c}, exp_q_c[0]);
        end
      end else if (o_ctrl_c !== '0) begin
        n_fail++; $display("FAIL comb_bubble_ctrl got %h want 0", o_ctrl_c);
      end
    end
    ea_s = v && rdy_s;  er_s = rdy && (exp_q_s.size() != 0);
    ea_c = v && rdy_c;  er_c = rdy && (exp_q_c.size() != 0);
    if (rs || fl) begin
      exp_q_s.delete();
      exp_q_c.delete();
    end else begin
      if (er_s) void'(exp_q_s.pop_front());
      if (ea_s) exp_q_s.push_back({c, d});
      if (er_c) void'(exp_q_c.pop_front());
      if (ea_c) exp_q_c.push_back({c, d});
    end
    @(posedge i_clock);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, CW'($urandom), rand_data(), rdy, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    armed = 1'b1;
    #1;
    n_checks++;
    if ({o_valid_s, o_valid_c} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valid got %b want 00", {o_valid_s, o_valid_c});
    end
    n_checks++;
    if ({o_ready_s, o_ready_c} !== 2'b11) begin
      n_fail++; $display("FAIL reset_ready got %b want 11", {o_ready_s, o_ready_c});
    end
    n_checks++;
    if ({o_data_s, o_data_c, o_ctrl_s, o_ctrl_c} !== '0) begin
      n_fail++; $display("FAIL reset_fields got %h %h want 0", o_data_s, o_data_c);
    end
    n_checks++;
    if ({o_count_s, o_count_c} !== 4'd0) begin
      n_fail++; $display("FAIL reset_count got %0d %0d want 0", o_count_s, o_count_c);
    end
  endtask

  task automatic test_single();
    cycle(1'b1, 10'h155, DW'(1), 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({o_valid_s, o_ctrl_s, o_count_s} !== {1'b1, 10'h155, 2'd1}) begin
      n_fail++; $display("FAIL single got v=%0b c=%h n=%0d want v=1 c=155 n=1", o_valid_s, o_ctrl_s, o_count_s);
    end
    idle(1'b1);
    idle(1'b1);
  endtask

  task automatic test_skid_fill();
    cycle(1'b1, 10'd1, DW'(1), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 10'd2, DW'(2), 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if ({o_count_s, o_ready_s} !== {2'd2, 1'b0}) begin
      n_fail++; $display("FAIL skid_full got n=%0d r=%0b want n=2 r=0", o_count_s, o_ready_s);
    end
    idle(1'b0);
    idle(1'b1);
    #1;
    n_checks++;
    if ({o_valid_s, o_data_s} !== {1'b1, DW'(2)}) begin
      n_fail++; $display("FAIL skid_second got v=%0b d=%0d want v=1 d=2", o_valid_s, o_data_s);
    end
    idle(1'b1);
    idle(1'b1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, CW'($urandom_range(1, 1023)), DW'(i), 1'b1, 1'b0, 1'b0);
      #1;
      n_checks++;
      if ({o_count_s, o_count_c} !== {2'd1, 2'd1}) begin
        n_fail++; $display("FAIL b2b_count got %0d %0d want 1 1", o_count_s, o_count_c);
      end
    end
    idle(1'b1);
  endtask

  task automatic test_flush();
    cycle(1'b1, 10'd3, DW'(3), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 10'd4, DW'(4), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 10'd5, DW'(5), 1'b0, 1'b1, 1'b0);
    #1;
    n_checks++;
    if ({o_valid_s, o_ctrl_s, o_count_s, o_ready_s} !== {1'b0, 10'd0, 2'd0, 1'b1}) begin
      n_fail++; $display("FAIL flush got v=%0b c=%h n=%0d r=%0b want 0 0 0 1", o_valid_s, o_ctrl_s, o_count_s, o_ready_s);
    end
    idle(1'b0);
  endtask

  task automatic test_reset_flush();
    cycle(1'b1, 10'd6, DW'(6), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 10'd7, DW'(7), 1'b0, 1'b1, 1'b1);
    #1;
    n_checks++;
    if ({o_valid_s, o_valid_c, o_ctrl_s, o_ctrl_c, o_data_s, o_data_c} !== '0) begin
      n_fail++; $display("FAIL rst_flush got v=%0b%0b d=%h %h want 0", o_valid_s, o_valid_c, o_data_s, o_data_c);
    end
    n_checks++;
    if ({o_count_s, o_count_c, o_ready_s, o_ready_c} !== {4'd0, 2'b11}) begin
      n_fail++; $display("FAIL rst_flush_cnt got %0d %0d r=%0b%0b want 0 0 11", o_count_s, o_count_c, o_ready_s, o_ready_c);
    end
    idle(1'b0);
  endtask

  task automatic test_comb_ready();
    cycle(1'b1, 10'd8, DW'(8), 1'b0, 1'b0, 1'b0);
    @(negedge i_clock);
    i_valid = 1'b0; i_ready = 1'b0;
    #1;
    n_checks++;
    if ({o_ready_c, o_ready_s} !== 2'b01) begin
      n_fail++; $display("FAIL comb_stall got c=%0b s=%0b want c=0 s=1", o_ready_c, o_ready_s);
    end
    i_ready = 1'b1;
    #1;
    n_checks++;
    if (o_ready_c !== 1'b1) begin
      n_fail++; $display("FAIL comb_release got %0b want 1", o_ready_c);
    end
    i_ready = 1'b0;
    idle(1'b1);
    idle(1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), CW'($urandom), rand_data(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, 1'b0);
    end
    for (int i = 0; i < 3; i++) idle(1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_skid_fill();
    test_back_to_back();
    test_flush();
    test_reset_flush();
    test_comb_ready();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter NB_CTRL, default 10, width of the control field (reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dest, alu_op[2:0]).
REQ-002 SHALL have parameter NB_DATA, default 138, width of the payload field (pc, data_a, data_b, immediate, rt, rd).
REQ-003 SHALL have parameter SKID, default 1: 1 = two-entry skid buffer with registered o_ready; 0 = single register with combinational o_ready.
REQ-004 SHALL have port i_clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_flush  input  1  synchronous discard of all held entries.
REQ-007 SHALL have port i_valid  input  1  upstream entry offered.
REQ-008 SHALL have port o_ready  output  1  stage accepts an entry this cycle.
REQ-009 SHALL have port i_ctrl  input  NB_CTRL  upstream control field.
REQ-010 SHALL have port i_data  input  NB_DATA  upstream payload field.
REQ-011 SHALL have port o_valid  output  1  output entry valid.
REQ-012 SHALL have port i_ready  input  1  downstream accepts.
REQ-013 SHALL have port o_ctrl  output  NB_CTRL  output control field.
REQ-014 SHALL have port o_data  output  NB_DATA  output payload field.
REQ-015 SHALL have port o_count  output  2  entries held (0..2; max 1 when SKID=0).

Function
REQ-016 SHALL accept an entry only when i_valid && o_ready, and retire one only when o_valid && i_ready.
REQ-017 SHALL have states EMPTY (0 held), FULL (main only), SKID (main + skid); SKID state unreachable when SKID=0.
REQ-018 SHALL transition EMPTY->FULL on accept; FULL->EMPTY on retire without accept; FULL->SKID on accept without retire (SKID=1); SKID->FULL on retire; all other cases hold state.
REQ-019 SHALL, in FULL with simultaneous accept and retire, load main from input in one cycle and remain FULL.
REQ-020 SHALL, on SKID->FULL, move the skid entry into main, preserving order; no entry is lost or duplicated.
REQ-021 SHALL (SKID=1) drive o_ready from a flop: 1 in EMPTY/FULL, 0 in SKID; no combinational path i_ready->o_ready.
REQ-022 SHALL (SKID=0) drive o_ready = !o_valid || i_ready.
REQ-023 SHALL give one-cycle latency: an entry accepted at edge N appears on o_ctrl/o_data with o_valid=1 after edge N.
REQ-024 SHALL hold o_ctrl and o_data stable while o_valid && !i_ready.
REQ-025 SHALL force o_ctrl to all-zero whenever o_valid=0 (bubble); o_data keeps its last value.
REQ-026 SHALL, on i_flush, go to EMPTY on the next edge, discarding main, skid, and any entry accepted in the same cycle; o_ready=1 afterwards.
REQ-027 SHALL give i_reset priority over i_flush, and i_flush priority over accept/retire.
REQ-028 SHALL never read i_ctrl/i_data when i_valid=0.

Reset
REQ-029 SHALL, on i_reset at a rising edge, set state EMPTY, o_valid=0, o_ctrl=0, o_data=0, skid storage=0, o_count=0, o_ready=1.
REQ-030 SHALL discard held entries when reset is asserted mid-operation, with no entry emitted after reset deasserts until a new accept.

Structure
REQ-031 SHALL place state encoding (EMPTY/FULL/SKID) and default NB_CTRL/NB_DATA constants in shared package pipe_pkg.
REQ-032 SHALL be one flat module; no sub-module, since main/skid storage is two register fields handled by a single FSM.

Verification
REQ-033 SHALL cover: reset, then i_valid=1, i_ctrl=10'h155, i_data=1 -> o_valid=1, o_ctrl=10'h155 one cycle later, o_count=1.
REQ-034 SHALL cover: SKID=1, i_ready=0, offer A=1 then B=2 -> o_count=2, o_ready=0; raise i_ready -> outputs A then B on consecutive cycles.
REQ-035 SHALL cover: FULL with i_valid=1 and i_ready=1 for 8 cycles, data 0..7 -> output 0..7 back-to-back, o_count stays 1.
REQ-036 SHALL cover: SKID state, i_flush=1 with i_valid=1 -> next cycle o_valid=0, o_ctrl=0, o_count=0, o_ready=1.
REQ-037 SHALL cover: i_reset and i_flush together while FULL -> all outputs at reset values; o_ctrl=0 while o_valid=0.
REQ-038 SHALL cover: SKID=0, FULL with i_ready=0 -> o_ready=0 same cycle; i_ready=1 -> o_ready=1 same cycle.
